// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor: operand input channel,
// result output channel and status.
// Optional: SERIAL_SUB_SIGNED_OVF_EN adds the signed overflow flag ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles,
// one full-subtractor bit per clock, valid/ready on both sides.
// Optional: SERIAL_SUB_SIGNED_OVF_EN adds the registered signed overflow flag.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// SHIFT | processing one bit per clock
// DONE  | result held, out_valid high until out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic             bout_q;
    logic             diff_bit_d;
    logic             br_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand MSBs are kept aside because a_q/b_q shift them away.
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    // Full-subtractor slice on the current LSBs and running borrow.
    always_comb begin
        diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d       = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    end

    // Control FSM and serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.bin;
                        cnt_q   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1];
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_q <= {diff_bit_d, res_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        bout_q  <= br_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        // The bit computed now is the result MSB.
                        ovf_q   <= (a_msb_q != b_msb_q) && (diff_bit_d != a_msb_q);
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.diff      = res_q;
    assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        int           stall;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from plain arithmetic; ovf follows the MSB rule on
    // the captured operands and the resulting difference.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        longint t;
        t  = longint'(a) - longint'(b) - longint'(bin);
        d  = t[W-1:0];
        bo = (t < 0);
        ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!sif.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!sif.in_ready) chk({name, " in_ready timeout"}, 0, 1);
    endtask

    // Returns the number of edges from acceptance until out_valid.
    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!sif.out_valid && cyc < 4 * W) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] d, input logic bo,
                                input logic ov);
        chk({name, " diff"}, 64'(sif.diff), 64'(d));
        chk({name, " bout"}, 64'(sif.bout), 64'(bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk({name, " ovf"}, 64'(sif.ovf), 64'(ov));
`else
        if (ov === 1'bx) chk({name, " ovf x"}, 0, 1);
`endif
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input int stall, input logic [W-1:0] d,
                         input logic bo, input logic ov);
        int cyc;
        wait_in_ready(name);
        sif.out_ready = (stall == 0);
        sif.a = a;
        sif.b = b;
        sif.bin = bin;
        sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0;
        sif.a = ~a;
        sif.b = ~b;
        sif.bin = ~bin;
        chk({name, " busy after accept"}, {62'd0, sif.busy, sif.in_ready}, 64'b10);
        wait_out_valid(cyc);
        chk({name, " latency"}, 64'(cyc), 64'(W));
        check_result(name, d, bo, ov);
        for (int s = 0; s < stall; s++) begin
            sif.in_valid = 1'b1;
            sif.a = W'($urandom);
            sif.b = W'($urandom);
            step();
            sif.in_valid = 1'b0;
            chk({name, " held valid/ready"}, {62'd0, sif.out_valid, sif.in_ready}, 64'b10);
            check_result({name, " held"}, d, bo, ov);
        end
        sif.out_ready = 1'b1;
        step();
        chk({name, " handshake to idle"}, {61'd0, sif.out_valid, sif.in_ready, sif.busy},
            64'b010);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [W-1:0] ra, rb, ed, d1, d2;
        logic rbin, eb, eo, b1, b2, o1, o2, seen;
        int cyc;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        sif.in_valid = 1'b1;
        sif.a = 8'h55;
        sif.b = 8'h11;
        sif.bin = 1'b0;
        sif.out_ready = 1'b1;

        // Reset: outputs at reset values and nothing captured.
        repeat (3) step();
        chk("reset in_ready", 64'(sif.in_ready), 1);
        chk("reset out_valid/busy", {62'd0, sif.out_valid, sif.busy}, 0);
        chk("reset diff", 64'(sif.diff), 0);
        chk("reset bout", 64'(sif.bout), 0);
        sif.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle after reset", {62'd0, sif.in_ready, sif.busy}, 64'b10);

        // Directed vectors, with expectations worked out by hand.
        vecs.push_back('{8'h35, 8'h12, 1'b0, 0, 8'h23, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h10, 8'h10, 1'b1, 0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'hA0, 8'h0F, 1'b0, 5, 8'h91, 1'b0, 1'b0});
        vecs.push_back('{8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'hFF, 1'b0, 0, 8'h80, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 2, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 0, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{8'h5A, 8'h5A, 1'b0, 0, 8'h00, 1'b0, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_op($sformatf("vec%0d", i), v.a, v.b, v.bin, v.stall, v.exp_diff, v.exp_bout,
                  v.exp_ovf);
        end

        // Reset in the middle of SHIFT aborts the operation.
        sif.a = 8'hC3;
        sif.b = 8'h3C;
        sif.bin = 1'b1;
        sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("abort diff/bout", {55'd0, sif.diff, sif.bout}, 0);
        chk("abort valid/ready/busy", {61'd0, sif.out_valid, sif.in_ready, sif.busy}, 64'b010);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (sif.out_valid) seen = 1'b1;
        end
        chk("abort no out_valid", 64'(seen), 0);
        do_op("after abort", 8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0);

        // Back-to-back: in_valid held high across two operand sets.
        model(8'h9C, 8'h27, 1'b1, d1, b1, o1);
        model(8'h13, 8'hE4, 1'b0, d2, b2, o2);
        sif.out_ready = 1'b1;
        sif.a = 8'h9C;
        sif.b = 8'h27;
        sif.bin = 1'b1;
        sif.in_valid = 1'b1;
        step();
        sif.a = 8'h13;
        sif.b = 8'hE4;
        sif.bin = 1'b0;
        wait_out_valid(cyc);
        chk("b2b first latency", 64'(cyc), 64'(W));
        check_result("b2b first", d1, b1, o1);
        step();
        chk("b2b idle with valid", {62'd0, sif.in_ready, sif.out_valid}, 64'b10);
        step();
        sif.in_valid = 1'b0;
        chk("b2b second accepted", 64'(sif.busy), 1);
        wait_out_valid(cyc);
        chk("b2b second latency", 64'(cyc), 64'(W));
        check_result("b2b second", d2, b2, o2);
        step();

        // Randomized operands and backpressure against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rbin, ed, eb, eo);
            do_op($sformatf("rand%0d a=%0h b=%0h bin=%0d", i, ra, rb, rbin), ra, rb, rbin,
                  int'($urandom_range(0, 2)), ed, eb, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
